// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between writeback requesters and the register-bank arbiter.
// Optional lock lane is present only when REGWR_LOCK_EN is defined.
interface regfile_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREG-1:0]    wr_en;
  logic [DW-1:0]      wr_data;
  logic               addr_err;
`ifdef REGWR_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif

  modport master (
`ifdef REGWR_LOCK_EN
    output lock,
`endif
    output req, addr, wdata,
    input  gnt, wr_en, wr_data, addr_err
  );

  modport slave (
`ifdef REGWR_LOCK_EN
    input  lock,
`endif
    input  req, addr, wdata,
    output gnt, wr_en, wr_data, addr_err
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among NREQ sources.
// Define REGWR_LOCK_EN to add per-requester burst lock (lock port on the interface).
module regfile_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic            accept;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            in_range;
  logic [NREG-1:0] wr_en;
  logic [DW-1:0]   wr_data;
  logic            addr_err;
  int              idx;

`ifdef REGWR_LOCK_EN
  logic            lock_own;
  logic [PW-1:0]   owner;
  logic            held;

  assign held = lock_own & bus.req[owner] & bus.lock[owner];
`endif

  // Grant: first pending request from ptr onward; a held lock overrides.
  always_comb begin
    gnt    = '0;
    win    = ptr;
    accept = 1'b0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (bus.req[idx]) begin
        win    = PW'(idx);
        accept = 1'b1;
      end
    end
`ifdef REGWR_LOCK_EN
    if (held) begin
      win    = owner;
      accept = 1'b1;
    end
`endif
    if (accept) gnt[win] = 1'b1;
  end

  assign sel_addr = bus.addr[win*AW +: AW];
  assign sel_data = bus.wdata[win*DW +: DW];
  assign in_range = 32'(sel_addr) < 32'(NREG);

  // Pointer moves just past the accepted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= PW'((int'(win) + 1) % NREQ);
    end
  end

`ifdef REGWR_LOCK_EN
  // Lock ownership follows the lock bit of whoever was last accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_own <= 1'b0;
      owner    <= '0;
    end else if (accept) begin
      lock_own <= bus.lock[win];
      owner    <= win;
    end else begin
      lock_own <= 1'b0;
    end
  end
`endif

  // Write stage: one-hot enable and data to the bank, out-of-range is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= '0;
      wr_data  <= '0;
      addr_err <= 1'b0;
    end else if (accept) begin
      wr_data <= sel_data;
      if (in_range) begin
        wr_en    <= {{(NREG-1){1'b0}}, 1'b1} << sel_addr;
        addr_err <= 1'b0;
      end else begin
        wr_en    <= '0;
        addr_err <= 1'b1;
      end
    end else begin
      wr_en    <= '0;
      addr_err <= 1'b0;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.wr_en    = wr_en;
  assign bus.wr_data  = wr_data;
  assign bus.addr_err = addr_err;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter (NREQ=4, NREG=24).
// Lock scenario runs only when REGWR_LOCK_EN is defined.
module tb_regfile_wr_arbiter;
  localparam int NREQ = 4;
  localparam int NREG = 24;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct {
    logic [NREG-1:0] en;
    logic [DW-1:0]   data;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;

  exp_t sb[$];
  int   m_ptr = 0;
  logic [DW-1:0] m_data = '0;
  logic m_lock_own = 1'b0;
  int   m_owner = 0;

  regfile_wr_arbiter_if #(
    .NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)
  ) bus ();

  regfile_wr_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] m_pick(input logic [NREQ-1:0] r,
                                             input logic [NREQ-1:0] l);
    if (m_lock_own && r[m_owner] && l[m_owner])
      return NREQ'(1) << m_owner;
    for (int k = 0; k < NREQ; k++) begin
      if (r[(m_ptr + k) % NREQ]) return NREQ'(1) << ((m_ptr + k) % NREQ);
    end
    return '0;
  endfunction

  function automatic logic [NREQ*AW-1:0] pa(input int a0, a1, a2, a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [NREQ*DW-1:0] pd(input logic [DW-1:0] d0, d1,
                                            d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                      input logic [NREQ*AW-1:0] a,
                      input logic [NREQ*DW-1:0] d,
                      output logic [NREQ-1:0] g);
    logic [NREQ-1:0] eg;
    logic [AW-1:0] ea;
    exp_t e;
    int w;
    bus.req   = r;
    bus.addr  = a;
    bus.wdata = d;
`ifdef REGWR_LOCK_EN
    bus.lock  = l;
`endif
    #1;
    eg = m_pick(r, l);
    g  = bus.gnt;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    e.en = '0;
    e.err = 1'b0;
    e.data = m_data;
    if (eg != '0) begin
      w = 0;
      for (int i = 0; i < NREQ; i++) if (eg[i]) w = i;
      ea = a[w*AW +: AW];
      e.data = d[w*DW +: DW];
      if (int'(ea) < NREG) e.en = NREG'(1) << ea;
      else e.err = 1'b1;
      m_ptr = (w + 1) % NREQ;
      m_lock_own = l[w];
      m_owner = w;
    end else begin
      m_lock_own = 1'b0;
    end
    m_data = e.data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk("wr_en", 32'(bus.wr_en), 32'(e.en));
      chk("wr_data", bus.wr_data, e.data);
      chk("addr_err", 32'(bus.addr_err), 32'(e.err));
    end
    @(negedge clk);
  endtask

  logic [NREQ-1:0] g;
  logic [NREQ*AW-1:0] fa;
  logic [NREQ*DW-1:0] fd;

  initial begin
    bus.req   = 4'b1111;
    bus.addr  = pa(1, 2, 3, 4);
    bus.wdata = '0;
`ifdef REGWR_LOCK_EN
    bus.lock  = '0;
`endif
    #2;
    chk("rst_gnt", 32'(bus.gnt), 32'h1);
    chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    chk("rst_addr_err", 32'(bus.addr_err), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    fa = pa(3, 7, 11, 19);
    fd = pd(32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'hD3D3_3333);
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 4'b0000, fa, fd, g);
      chk("order", 32'(g), 32'(1) << (i % 4));
    end

    step(4'b0100, 4'b0000, pa(0, 0, 5, 0),
         pd(32'h0, 32'h0, 32'hDEADBEEF, 32'h0), g);
    chk("single_gnt", 32'(g), 32'h4);
    chk("single_en", 32'(bus.wr_en), 32'h20);
    chk("single_data", bus.wr_data, 32'hDEADBEEF);
    step(4'b0000, 4'b0000, '0, '0, g);
    chk("single_idle", 32'(bus.wr_en), 32'h0);

    step(4'b0101, 4'b0000, pa(1, 0, 2, 0),
         pd(32'h1111, 32'h0, 32'h2222, 32'h0), g);
    chk("wrap_gnt0", 32'(g), 32'h1);
    step(4'b0100, 4'b0000, pa(1, 0, 2, 0),
         pd(32'h1111, 32'h0, 32'h2222, 32'h0), g);
    chk("wrap_gnt2", 32'(g), 32'h4);

    step(4'b0010, 4'b0000, pa(0, 30, 0, 0),
         pd(32'h0, 32'hBAD0_0001, 32'h0, 32'h0), g);
    chk("bad_gnt", 32'(g), 32'h2);
    chk("bad_err", 32'(bus.addr_err), 32'h1);
    chk("bad_en", 32'(bus.wr_en), 32'h0);
    step(4'b0000, 4'b0000, '0, '0, g);
    chk("bad_err_clr", 32'(bus.addr_err), 32'h0);

    step(4'b0001, 4'b0000, pa(9, 0, 0, 0),
         pd(32'h1234_5678, 32'h0, 32'h0, 32'h0), g);
    chk("pre_rst_en", 32'(bus.wr_en), 32'h200);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(bus.wr_en), 32'h0);
    chk("mid_rst_data", bus.wr_data, 32'h0);
    m_ptr = 0;
    m_data = '0;
    m_lock_own = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1110, 4'b0000, fa, fd, g);
    chk("post_rst_gnt", 32'(g), 32'h2);

`ifdef REGWR_LOCK_EN
    step(4'b1000, 4'b0000, fa, fd, g);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, 4'b0001, fa, fd, g);
      chk("lock_gnt", 32'(g), 32'h1);
    end
    step(4'b0011, 4'b0000, fa, fd, g);
    chk("unlock_gnt", 32'(g), 32'h2);
`endif

    for (int i = 0; i < 24; i++) begin
      step(4'($urandom_range(0, 15)), 4'b0000,
           pa($urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31)),
           pd($urandom, $urandom, $urandom, $urandom), g);
    end
    step(4'b0000, 4'b0000, '0, '0, g);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
